// File: rtl/slice_scheduler_pkg.sv
// Shared types and default sizes for the slice scheduler and its watchdog.
package slice_scheduler_pkg;

    localparam int unsigned WORD_W_DEF   = 32;
    localparam int unsigned IDX_W_DEF    = 4;
    localparam int unsigned TIMER_RELOAD = 127;
    // Watchdog width follows from the all-ones reload value.
    localparam int unsigned TMR_W_DEF    = $clog2(TIMER_RELOAD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OUTER,
        S_INNER,
        S_DONE
    } state_t;

endpackage

// File: rtl/slice_watchdog.sv
// Reloadable down-counter that flags when the count has reached zero.
module slice_watchdog
    import slice_scheduler_pkg::*;
#(
    parameter int unsigned TMR_W = TMR_W_DEF
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             reload,
    input  logic             tick,
    output logic             expired,
    output logic [TMR_W-1:0] count
);

    localparam logic [TMR_W-1:0] RELOAD = '1;

    logic [TMR_W-1:0] count_nxt;

    // Reload wins over tick; the count saturates at zero.
    always_comb begin
        count_nxt = count;
        if (reload) begin
            count_nxt = RELOAD;
        end else if (tick && (count != '0)) begin
            count_nxt = count - TMR_W'(1);
        end
    end

    // Count register plus a registered zero flag kept in step with it.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= RELOAD;
            expired <= 1'b0;
        end else begin
            count   <= count_nxt;
            expired <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/slice_scheduler.sv
// Nested-loop word scheduler: walks i=0..M outer, k=B..0 inner, accumulating
// i once per outer pass and every accepted rd_word, guarded by a watchdog.
module slice_scheduler
    import slice_scheduler_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF,
    parameter int unsigned TMR_W  = TMR_W_DEF
) (
    input  logic              sysclk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  outer_max,
    input  logic [IDX_W-1:0]  inner_base,
    output logic [IDX_W-1:0]  sel_idx,
    output logic              sel_valid,
    input  logic              sel_ready,
    input  logic [WORD_W-1:0] rd_word,
    output logic [WORD_W-1:0] acc_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t             state;
    logic [IDX_W-1:0]   m_q;
    logic [IDX_W-1:0]   b_q;
    logic [IDX_W-1:0]   i_q;
    logic [IDX_W-1:0]   k_q;
    logic [TMR_W-1:0]   timer_cnt;
    logic               expired;
    logic               handshake;
    logic               wd_reload;
    logic               wd_tick;

    assign handshake = sel_valid & sel_ready;
    assign sel_idx   = k_q;

    // Watchdog restarts on every sign of progress and counts stalled INNER cycles.
    assign wd_reload = ((state == S_IDLE) && start) || (state == S_OUTER) || handshake;
    assign wd_tick   = (state == S_INNER) && !sel_ready;

    slice_watchdog #(
        .TMR_W (TMR_W)
    ) u_watchdog (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .reload  (wd_reload),
        .tick    (wd_tick),
        .expired (expired),
        .count   (timer_cnt)
    );

    // FSM, loop counters, accumulator and registered status outputs.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            m_q       <= '0;
            b_q       <= '0;
            i_q       <= '0;
            k_q       <= '0;
            acc_out   <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_q     <= outer_max;
                        b_q     <= inner_base;
                        i_q     <= '0;
                        acc_out <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_OUTER;
                    end
                end
                S_OUTER: begin
                    acc_out   <= acc_out + WORD_W'(i_q);
                    k_q       <= b_q;
                    sel_valid <= 1'b1;
                    state     <= S_INNER;
                end
                S_INNER: begin
                    if (handshake) begin
                        acc_out <= acc_out + rd_word;
                        if (k_q == '0) begin
                            sel_valid <= 1'b0;
                            if (i_q == m_q) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                i_q   <= i_q + IDX_W'(1);
                                state <= S_OUTER;
                            end
                        end else begin
                            k_q <= k_q - IDX_W'(1);
                        end
                    end else if (expired) begin
                        err       <= 1'b1;
                        sel_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The registered zero flag must always agree with the live count.
    a_expired_matches_count: assert property (
        @(posedge sysclk) disable iff (!reset_n) expired == (timer_cnt == '0)
    );

endmodule

// File: tb/tb_slice_scheduler.sv
// Directed bench for slice_scheduler: table of runs plus reset sequences.
module tb_slice_scheduler;

    logic        sysclk;
    logic        reset_n;
    logic        start;
    logic [3:0]  outer_max;
    logic [3:0]  inner_base;
    logic [3:0]  sel_idx;
    logic        sel_valid;
    logic        sel_ready;
    logic [31:0] rd_word;
    logic [31:0] acc_out;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    slice_scheduler dut (
        .sysclk     (sysclk),
        .reset_n    (reset_n),
        .start      (start),
        .outer_max  (outer_max),
        .inner_base (inner_base),
        .sel_idx    (sel_idx),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .rd_word    (rd_word),
        .acc_out    (acc_out),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct {
        string       name;
        logic [3:0]  m;
        logic [3:0]  b;
        int          stall;
        logic [31:0] rd_base;
        logic [31:0] rd_step;
        bit          mid_start;
        logic [31:0] exp_acc;
        int          exp_hs;
        int          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts a run at the current negedge (DUT in IDLE) and watches it to completion.
    task automatic run_vec(input vec_t v);
        int          hs;
        int          wait_cnt;
        int          done_cyc;
        int          idx_bad;
        int          unstable;
        int          e;
        logic [3:0]  held_idx;
        hs = 0; wait_cnt = 0; done_cyc = -1; idx_bad = 0; unstable = 0; held_idx = '0;
        outer_max  = v.m;
        inner_base = v.b;
        sel_ready  = 1'b0;
        start      = 1'b1;
        @(posedge sysclk);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge sysclk);
            start = v.mid_start && (cyc == 3);
            if (start) begin
                outer_max  = 4'd5;
                inner_base = 4'd5;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (sel_valid) begin
                if (wait_cnt == 0) held_idx = sel_idx;
                else if (sel_idx !== held_idx) unstable++;
                if (wait_cnt >= v.stall) begin
                    sel_ready = 1'b1;
                    rd_word   = v.rd_base + v.rd_step * 32'(hs);
                    e = int'(v.b) - (hs % (int'(v.b) + 1));
                    if (sel_idx !== 4'(e)) idx_bad++;
                    hs++;
                    wait_cnt = 0;
                end else begin
                    sel_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                sel_ready = 1'b0;
            end
        end
        sel_ready = 1'b0;
        start     = 1'b0;
        check({v.name, " done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
        check({v.name, " acc_out"}, acc_out, v.exp_acc);
        check({v.name, " err"}, 32'(err), 32'(v.exp_err));
        check({v.name, " handshakes"}, 32'(hs), 32'(v.exp_hs));
        check({v.name, " sel_idx_order_errors"}, 32'(idx_bad), 32'd0);
        check({v.name, " sel_idx_unstable"}, 32'(unstable), 32'd0);
        @(negedge sysclk);
        check({v.name, " done_one_cycle"}, 32'(done), 32'd0);
        check({v.name, " busy_after"}, 32'(busy), 32'd0);
        check({v.name, " acc_held"}, acc_out, v.exp_acc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " acc_out"}, acc_out, 32'd0);
        check({tag, " sel_idx"}, 32'(sel_idx), 32'd0);
        check({tag, " sel_valid"}, 32'(sel_valid), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
    endtask

    initial begin
        //          name       m     b     stall rd_base        rd_step mid   exp_acc        hs  done err
        vecs[0] = '{"basic",   4'd1, 4'd1, 0,    32'd10,        32'd10, 1'b0, 32'd101,       4,  7,   1'b0};
        vecs[1] = '{"minimal", 4'd0, 4'd0, 0,    32'd5,         32'd0,  1'b0, 32'd5,         1,  3,   1'b0};
        vecs[2] = '{"bkpress", 4'd0, 4'd2, 3,    32'd1,         32'd1,  1'b0, 32'd6,         3,  14,  1'b0};
        vecs[3] = '{"wrap",    4'd0, 4'd1, 0,    32'hFFFFFFFF,  32'd0,  1'b1, 32'hFFFFFFFE,  2,  4,   1'b0};
        vecs[4] = '{"outer3",  4'd2, 4'd0, 0,    32'd100,       32'd0,  1'b0, 32'd303,       3,  7,   1'b0};
        vecs[5] = '{"timeout", 4'd0, 4'd0, 1000, 32'd9,         32'd0,  1'b0, 32'd0,         0,  130, 1'b1};
        vecs[6] = '{"m3b2st1", 4'd3, 4'd2, 1,    32'd1,         32'd0,  1'b0, 32'd18,        12, 29,  1'b0};

        reset_n    = 1'b0;
        start      = 1'b0;
        outer_max  = '0;
        inner_base = '0;
        sel_ready  = 1'b0;
        rd_word    = '0;
        #3;
        check_reset_outputs("por");
        @(negedge sysclk);
        reset_n = 1'b1;

        // First run starts on the very first edge after reset release.
        foreach (vecs[n]) run_vec(vecs[n]);

        // Reset in the middle of an INNER phase.
        outer_max  = 4'd2;
        inner_base = 4'd2;
        rd_word    = 32'd7;
        sel_ready  = 1'b1;
        start      = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        start = 1'b0;
        @(negedge sysclk);
        @(negedge sysclk);
        check("midrst pre_busy", 32'(busy), 32'd1);
        check("midrst pre_acc", acc_out, 32'd7);
        check("midrst pre_idx", 32'(sel_idx), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sel_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge sysclk);
            check("midrst no_done", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        run_vec(vecs[1]);
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
